soc_vga_fetch: RTL and testbench

Framebuffer prefetch stage feeding the SoC VGA controller. Reads 32-bit words from the framebuffer in system memory through a single-outstanding request/acknowledge port and buffers them in a small FIFO. Serves one 8-bit RGB332 pixel per cycle on `pixel_data`, selected combinationally by the controller's `pixel_address`. Sits between the memory/bus fabric and the VGA timing controller.

---
 rtl/soc_vga_pkg.sv | 22 ++
 rtl/soc_vga_fetch_fifo.sv | 76 +++++++
 rtl/soc_vga_fetch.sv | 157 +++++++++++++++
 tb/tb_soc_vga_fetch.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/soc_vga_pkg.sv
// Shared definitions for the SoC VGA path: fetch FSM states, RGB332 field
// widths and the default 640x480 frame geometry.
package soc_vga_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

    localparam int RGB332_R_W = 3;
    localparam int RGB332_G_W = 3;
    localparam int RGB332_B_W = 2;
    localparam int PIXEL_W    = RGB332_R_W + RGB332_G_W + RGB332_B_W;

    localparam int H_ACTIVE             = 640;
    localparam int V_ACTIVE             = 480;
    localparam int FRAME_PIXELS_DEFAULT = H_ACTIVE * V_ACTIVE;

    localparam logic [31:0] FB_BASE_DEFAULT = 32'h0001_0000;

endpackage

// File: rtl/soc_vga_fetch_fifo.sv
// Word FIFO for the framebuffer prefetch: push, pop, flush, occupancy count
// and a combinational head word. Flush wins over a simultaneous push.
module soc_vga_fetch_fifo
    import soc_vga_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;
    logic             full;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign count = count_q;
    assign head  = mem_q[rd_q];

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop) && !flush;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PTR_ONE;
            if (do_pop)  rd_d = rd_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/soc_vga_fetch.sv
// Framebuffer prefetch for the VGA controller: single-outstanding word reads
// into a FIFO, one RGB332 pixel served per cycle. SOC_VGA_FETCH_UNDERRUN_CNT_EN
// adds a saturating underrun_count output.
module soc_vga_fetch
    import soc_vga_pkg::*;
#(
    parameter logic [31:0] FB_BASE      = FB_BASE_DEFAULT,
    parameter int          FRAME_PIXELS = FRAME_PIXELS_DEFAULT,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] pixel_address,
    output logic [7:0]  pixel_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        underrun
`ifdef SOC_VGA_FETCH_UNDERRUN_CNT_EN
    , output logic [15:0] underrun_count
`endif
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] FB_LAST = FB_BASE + 32'(FRAME_PIXELS) - 32'd4;

    fetch_state_e state_q, state_d;
    logic         mem_req_q, mem_req_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic [31:0]  fetch_ptr_q, fetch_ptr_d;
    logic         underrun_q, underrun_d;
    logic [31:0]  prev_addr_q, prev_addr_d;

    logic [31:0]  fifo_head;
    logic [AW:0]  fifo_count;
    logic         fifo_empty;
    logic [AW:0]  free_slots;
    logic         frame_bnd;
    logic         flush;
    logic         pop_req;
    logic         push;
    logic         underrun_evt;
    logic [31:0]  ptr_next;

    soc_vga_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .res   (res),
        .push  (push),
        .pop   (pop_req),
        .flush (flush),
        .wdata (mem_rdata),
        .head  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign underrun = underrun_q;

    always_comb begin
        pixel_data = 8'h00;
        if (!fifo_empty) pixel_data = fifo_head[{pixel_address[1:0], 3'b000} +: 8];
    end

    always_comb begin
        frame_bnd    = (pixel_address == 32'd0) && (prev_addr_q != 32'd0);
        flush        = frame_bnd && underrun_q;
        // Only a consecutive step onto a word boundary consumes a word.
        pop_req      = (pixel_address == prev_addr_q + 32'd1) && (pixel_address[1:0] == 2'b00);
        underrun_evt = pop_req && fifo_empty;
        push         = (state_q == FETCH_REQ) && mem_ack;
        free_slots   = DEPTH_C - fifo_count - {{AW{1'b0}}, (state_q == FETCH_REQ)};
        ptr_next     = (fetch_ptr_q == FB_LAST) ? FB_BASE : fetch_ptr_q + 32'd4;

        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        fetch_ptr_d  = fetch_ptr_q;
        prev_addr_d  = pixel_address;

        case (state_q)
            FETCH_IDLE: begin
                if (free_slots != '0 && !flush) begin
                    state_d    = FETCH_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_ptr_q;
                end
            end
            FETCH_REQ: begin
                // An ack arriving with the flush completes the request; its data is dropped.
                if (mem_ack) begin
                    state_d     = FETCH_IDLE;
                    mem_req_d   = 1'b0;
                    fetch_ptr_d = ptr_next;
                end else if (flush) begin
                    state_d = FETCH_DRAIN;
                end
            end
            FETCH_DRAIN: begin
                if (mem_ack) begin
                    state_d   = FETCH_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = FETCH_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        if (flush) fetch_ptr_d = FB_BASE;

        underrun_d = underrun_q || underrun_evt;
        if (frame_bnd) underrun_d = 1'b0;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= FETCH_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= FB_BASE;
            fetch_ptr_q <= FB_BASE;
            underrun_q  <= 1'b0;
            prev_addr_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            fetch_ptr_q <= fetch_ptr_d;
            underrun_q  <= underrun_d;
            prev_addr_q <= prev_addr_d;
        end
    end

`ifdef SOC_VGA_FETCH_UNDERRUN_CNT_EN
    logic [15:0] underrun_count_q, underrun_count_d;

    assign underrun_count = underrun_count_q;

    always_comb begin
        underrun_count_d = underrun_count_q;
        if (underrun_evt && underrun_count_q != 16'hFFFF) underrun_count_d = underrun_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) underrun_count_q <= 16'd0;
        else     underrun_count_q <= underrun_count_d;
    end
`endif

endmodule

// File: tb/tb_soc_vga_fetch.sv
// Directed bench for soc_vga_fetch with a 32-pixel frame and an 8-word FIFO.
module tb_soc_vga_fetch;

    logic        clk;
    logic        res;
    logic [31:0] pixel_address;
    logic [7:0]  pixel_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        underrun;
`ifdef SOC_VGA_FETCH_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    soc_vga_fetch #(
        .FB_BASE      (32'h0001_0000),
        .FRAME_PIXELS (32),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk           (clk),
        .res           (res),
        .pixel_address (pixel_address),
        .pixel_data    (pixel_data),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .underrun      (underrun)
`ifdef SOC_VGA_FETCH_UNDERRUN_CNT_EN
        , .underrun_count (underrun_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [31:0] a);
        pixel_address = a;
        #1;
    endtask

    // Memory contents: word i of the framebuffer is 0x44332211 + i*0x04040404.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'h4433_2211 + ((a - 32'h0001_0000) >> 2) * 32'h0404_0404;
    endfunction

    task automatic ack_req(input int lat, input logic [31:0] exp_addr);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 50) begin
            cyc();
            n++;
        end
        check("req_seen", {31'd0, mem_req}, 32'd1);
        check("req_addr", mem_addr, exp_addr);
        repeat (lat) cyc();
        mem_ack   = 1'b1;
        mem_rdata = word_of(exp_addr);
        cyc();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        check("req_drop", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        res           = 1'b1;
        pixel_address = 32'd0;
        mem_ack       = 1'b0;
        mem_rdata     = 32'd0;
        repeat (2) cyc();
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_addr", mem_addr, 32'h0001_0000);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_pixel", {24'd0, pixel_data}, 32'h00);
        res = 1'b0;

        // Fill: eight sequential word requests, then the FIFO is full.
        for (int i = 0; i < 8; i++) ack_req(2, 32'h0001_0000 + 32'(4 * i));
        repeat (4) cyc();
        check("full_no_req", {31'd0, mem_req}, 32'd0);

        // Little-endian byte select within the head word.
        set_addr(32'd0); check("byte0", {24'd0, pixel_data}, 32'h11); cyc();
        set_addr(32'd1); check("byte1", {24'd0, pixel_data}, 32'h22); cyc();
        set_addr(32'd2); check("byte2", {24'd0, pixel_data}, 32'h33); cyc();
        set_addr(32'd3); check("byte3", {24'd0, pixel_data}, 32'h44); cyc();
        set_addr(32'd4); check("pre_pop", {24'd0, pixel_data}, 32'h11);
        cyc();
        check("post_pop", {24'd0, pixel_data}, 32'h15);

        // Freed slot refills from the wrapped fetch pointer.
        ack_req(1, 32'h0001_0000);

        set_addr(32'd5); check("w1_b1", {24'd0, pixel_data}, 32'h26); cyc();
        set_addr(32'd6); check("w1_b2", {24'd0, pixel_data}, 32'h37); cyc();
        set_addr(32'd7); check("w1_b3", {24'd0, pixel_data}, 32'h48); cyc();
        set_addr(32'd8); cyc();
        check("w2_b0", {24'd0, pixel_data}, 32'h19);

        // Memory stalls from here on; the pending request stays up.
        for (int a = 9; a <= 31; a++) begin set_addr(32'(a)); cyc(); end
        check("w7_b3", {24'd0, pixel_data}, 32'h60);
        check("stall_req", {31'd0, mem_req}, 32'd1);
        check("stall_addr", mem_addr, 32'h0001_0004);
        set_addr(32'd32);
        check("w7_b0", {24'd0, pixel_data}, 32'h2D);
        cyc();
        check("next_frame_w0", {24'd0, pixel_data}, 32'h11);
        check("no_underrun", {31'd0, underrun}, 32'd0);

        // Frame restart without underrun: no flush, no pop.
        set_addr(32'd0); cyc();
        check("restart_head", {24'd0, pixel_data}, 32'h11);
        check("restart_underrun", {31'd0, underrun}, 32'd0);
        for (int a = 1; a <= 4; a++) begin set_addr(32'(a)); cyc(); end
        check("empty_pixel", {24'd0, pixel_data}, 32'h00);
        for (int a = 5; a <= 8; a++) begin set_addr(32'(a)); cyc(); end
        check("underrun_set", {31'd0, underrun}, 32'd1);
        for (int a = 9; a <= 32; a++) begin set_addr(32'(a)); cyc(); end
        check("underrun_sticky", {31'd0, underrun}, 32'd1);
        check("underrun_pixel", {24'd0, pixel_data}, 32'h00);
        check("underrun_req", {31'd0, mem_req}, 32'd1);
`ifdef SOC_VGA_FETCH_UNDERRUN_CNT_EN
        check("underrun_count", {16'd0, underrun_count}, 32'd7);
`endif

        // Boundary with underrun while in REQ: flush and drain.
        set_addr(32'd0); cyc();
        check("flush_clr", {31'd0, underrun}, 32'd0);
        check("drain_req", {31'd0, mem_req}, 32'd1);
        check("flush_pixel", {24'd0, pixel_data}, 32'h00);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        cyc();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        check("drain_done", {31'd0, mem_req}, 32'd0);
        check("drain_discard", {24'd0, pixel_data}, 32'h00);
        ack_req(2, 32'h0001_0000);
        check("realigned", {24'd0, pixel_data}, 32'h11);

        // Asynchronous reset in the middle of a request.
        cyc();
        check("mid_req", {31'd0, mem_req}, 32'd1);
        check("mid_addr", mem_addr, 32'h0001_0004);
        #2;
        res = 1'b1;
        #1;
        check("async_req", {31'd0, mem_req}, 32'd0);
        check("async_addr", mem_addr, 32'h0001_0000);
        check("async_pixel", {24'd0, pixel_data}, 32'h00);
        check("async_underrun", {31'd0, underrun}, 32'd0);
`ifdef SOC_VGA_FETCH_UNDERRUN_CNT_EN
        check("async_count", {16'd0, underrun_count}, 32'd0);
`endif
        cyc();
        res = 1'b0;
        ack_req(2, 32'h0001_0000);
        check("post_rst_pixel", {24'd0, pixel_data}, 32'h11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
